hilo_muldiv_ctrl: RTL and testbench



---
 rtl/hilo_muldiv_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_muldiv_ctrl
//  Description : Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the HI/LO pair.
//                Fixed-latency multiply, one-bit-per-cycle restoring divide,
//                one-cycle {HI,LO} write strobe on completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv_ctrl #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               flush,
  output logic               stall_req,
  output logic               busy,
  output logic               hl_write_enable,
  output logic [2*WIDTH-1:0] hl_data
);

  localparam int c_cnt_max = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_mul_last = c_cnt_w'(MUL_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(WIDTH - 1);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_mul  = 3'd1;
  localparam logic [2:0] c_st_div  = 3'd2;
  localparam logic [2:0] c_st_sign = 3'd3;
  localparam logic [2:0] c_st_done = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_a;      // multiplicand magnitude
  logic [WIDTH-1:0]   r_b;      // multiplier / divisor magnitude
  logic [WIDTH-1:0]   r_rem;    // partial remainder
  logic [WIDTH-1:0]   r_quo;    // dividend bits shifting out, quotient bits shifting in
  logic               r_q_neg;
  logic               r_r_neg;
  logic [2*WIDTH-1:0] r_hl;

  // Operand conditioning at issue: signed ops work on magnitudes
  logic               w_accept;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  assign w_accept = (r_state == c_st_idle) && start && !flush;
  assign w_signed = !op[0];
  assign w_a_neg  = w_signed && src_a[WIDTH-1];
  assign w_b_neg  = w_signed && src_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~src_a + 1'b1) : src_a;
  assign w_b_mag  = w_b_neg ? (~src_b + 1'b1) : src_b;

  // Product of magnitudes, negated when the operand signs differ
  logic [2*WIDTH-1:0] w_prod_mag;
  logic [2*WIDTH-1:0] w_mul_result;

  assign w_prod_mag   = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
  assign w_mul_result = r_q_neg ? (~w_prod_mag + 1'b1) : w_prod_mag;

  // One restoring-division step: bring in next dividend bit, trial-subtract
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;

  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_b};
  assign w_rem_next = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], !w_diff[WIDTH]};

  // Sign correction; a zero divisor passes the raw unsigned result through
  logic               w_div_zero;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_div_zero = (r_b == '0);
  assign w_quo_fix  = (r_q_neg && !w_div_zero) ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_fix  = (r_r_neg && !w_div_zero) ? (~r_rem + 1'b1) : r_rem;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_state_next;
  end

  // Next-state logic; flush aborts any state that has not yet committed
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (w_accept) w_state_next = op[1] ? c_st_div : c_st_mul;
      c_st_mul: begin
        if (flush)                    w_state_next = c_st_idle;
        else if (r_cnt == c_mul_last) w_state_next = c_st_done;
      end
      c_st_div: begin
        if (flush)                    w_state_next = c_st_idle;
        else if (r_cnt == c_div_last) w_state_next = c_st_sign;
      end
      c_st_sign: w_state_next = flush ? c_st_idle : c_st_done;
      c_st_done: w_state_next = c_st_idle;
      default:   w_state_next = c_st_idle;
    endcase
  end

  // Output decode; the stall drops in DONE so EX can move on
  always_comb begin
    stall_req       = w_accept || (r_state == c_st_mul) ||
                      (r_state == c_st_div) || (r_state == c_st_sign);
    busy            = (r_state != c_st_idle);
    hl_write_enable = (r_state == c_st_done);
  end

  assign hl_data = r_hl;

  // Datapath: operand capture, iteration and result registration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_hl    <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_cnt   <= '0;
            r_a     <= w_a_mag;
            r_b     <= w_b_mag;
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_q_neg <= w_a_neg ^ w_b_neg;
            r_r_neg <= w_a_neg;
          end
        end
        c_st_mul: begin
          r_cnt <= r_cnt + 1'b1;
          if ((r_cnt == c_mul_last) && !flush) r_hl <= w_mul_result;
        end
        c_st_div: begin
          r_cnt <= r_cnt + 1'b1;
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
        end
        c_st_sign: begin
          if (!flush) r_hl <= {w_rem_fix, w_quo_fix};
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_muldiv_ctrl
//  Description : Scoreboard testbench for hilo_muldiv_ctrl with directed and
//                random MULT/MULTU/DIV/DIVU traffic, flush and reset cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_ctrl;

  localparam int WIDTH      = 32;
  localparam int MUL_CYCLES = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall_req;
  logic        busy;
  logic        hl_write_enable;
  logic [63:0] hl_data;

  hilo_muldiv_ctrl #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .op              (op),
    .src_a           (src_a),
    .src_b           (src_b),
    .flush           (flush),
    .stall_req       (stall_req),
    .busy            (busy),
    .hl_write_enable (hl_write_enable),
    .hl_data         (hl_data)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  // Cycle index, advanced at every rising edge
  always @(posedge clk) cyc++;

  typedef struct {
    logic [63:0] data;
    int          when;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: MIPS HI/LO semantics from plain integer arithmetic
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_v, p, q, r;
    logic [63:0] ua, ub;
    logic [31:0] ma;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    case (o)
      2'b00: begin
        p = sa * sb_v;
        return p;
      end
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'd0) begin
          ma = a[31] ? (32'd0 - a) : a;
          return {ma, 32'hFFFF_FFFF};
        end
        q = sa / sb_v;
        r = sa % sb_v;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int latency(input logic [1:0] o);
    return o[1] ? (WIDTH + 2) : (MUL_CYCLES + 1);
  endfunction

  // Monitor: every write strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && hl_write_enable) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got hl_data %h with no pending op (cycle %0d)", hl_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hl_data", hl_data, e.data);
        check("strobe_cycle", 64'(cyc), 64'(e.when));
      end
    end
  end

  // All tasks are entered and left 1 time unit after a rising edge
  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy stuck at %b required 0", busy);
    end
  endtask

  // Issue one op, check stall/strobe timing cycle by cycle, expect a result
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int lat;
    exp_t e;
    wait_idle();
    lat   = latency(o);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    #1;
    check("stall_at_issue", 64'(stall_req), 64'd1);
    e.data = ref_model(o, a, b);
    e.when = cyc + lat;
    sb.push_back(e);
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (i == 1 || i >= lat - 1) begin
        check("stall_req", 64'(stall_req), 64'(i < lat));
        check("write_strobe", 64'(hl_write_enable), 64'(i == lat));
      end
    end
    @(posedge clk); #1;
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  // Present start for one cycle without scoring a result
  task automatic start_only(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] prev;
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    src_a = '0;
    src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", 64'(stall_req), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_strobe", 64'(hl_write_enable), 64'd0);
    check("reset_hl_data", hl_data, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    issue(2'b00, 32'hFFFF_FFFD, 32'd5);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE);
    issue(2'b11, 32'd100, 32'd0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b10, 32'hFFFF_FFF9, 32'd0);

    // Flush mid-divide: no strobe, hl_data retained, next op unaffected
    wait_idle();
    prev = hl_data;
    start_only(2'b11, 32'd1000, 32'd7);
    repeat (8) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hl_data", hl_data, prev);
    issue(2'b01, 32'd6, 32'd7);
    check("post_flush_mul", hl_data, 64'h0000_0000_0000_002A);

    // flush and start together in IDLE: nothing accepted
    op    = 2'b01;
    src_a = 32'd3;
    src_b = 32'd3;
    start = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_start_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);

    // Random traffic
    for (int k = 0; k < 40; k++) begin
      issue(2'($urandom_range(0, 3)), rand_operand(), rand_operand());
    end

    // Asynchronous reset in the middle of a divide
    wait_idle();
    start_only(2'b10, 32'd12345, 32'd17);
    repeat (4) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("arst_stall", 64'(stall_req), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_strobe", 64'(hl_write_enable), 64'd0);
    check("arst_hl_data", hl_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    check("arst_stays_idle", 64'(busy), 64'd0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
